// File: rtl/smvm_pkg.sv
// Shared sizing, state encoding and lane record for the SMVM batch scheduler.
// K lanes per batch, CREDITS output-buffer row slots (CREDITS >= K).
package smvm_pkg;

  localparam int K       = 4;
  localparam int VAL_W   = 8;
  localparam int COL_W   = 7;
  localparam int CREDITS = 8;

  localparam int LANE_W  = $clog2(K);
  localparam int CNT_W   = $clog2(K + 1);
  localparam int CRED_W  = $clog2(CREDITS + 1);
  localparam int LANES_W = 3;

  localparam logic [CNT_W-1:0]  K_LAST    = CNT_W'(K - 1);
  localparam logic [CRED_W-1:0] CREDITS_C = CRED_W'(CREDITS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  typedef struct packed {
    logic [VAL_W-1:0] val;
    logic [COL_W-1:0] col;
    logic             ipv;
  } lane_t;

  function automatic logic [CRED_W-1:0] popcount(input logic [K-1:0] v);
    logic [CRED_W-1:0] n;
    n = '0;
    for (int i = 0; i < K; i++) n = n + CRED_W'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/smvm_batch_scheduler_if.sv
// Nonzero-beat input stream and K-lane batch issue bus; master is the
// environment (beat source + ALU sink), slave is the scheduler.
interface smvm_batch_scheduler_if;
  import smvm_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [VAL_W-1:0]       in_val;
  logic [COL_W-1:0]       in_col;
  logic                   in_ipv;
  logic                   in_last;

  logic                   iss_valid;
  logic                   iss_ready;
  logic [VAL_W*K-1:0]     iss_val;
  logic [COL_W*K-1:0]     iss_col;
  logic [K-1:0]           iss_ipv;
  logic [LANES_W-1:0]     iss_lanes;

  modport master (
    output in_valid, in_val, in_col, in_ipv, in_last, iss_ready,
    input  in_ready, iss_valid, iss_val, iss_col, iss_ipv, iss_lanes
  );

  modport slave (
    input  in_valid, in_val, in_col, in_ipv, in_last, iss_ready,
    output in_ready, iss_valid, iss_val, iss_col, iss_ipv, iss_lanes
  );

endinterface

// File: rtl/smvm_credit_ctr.sv
// Output-buffer row credits: one consumed per row end issued, one returned per drained row.
// Latency: counts update at the edge after issue/return; err is sticky until rst.
module smvm_credit_ctr
  import smvm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [K-1:0]      ipv_vec,
  input  logic              issue,
  input  logic              cred_ret,
  output logic [CRED_W-1:0] need,
  output logic              can_issue,
  output logic              full,
  output logic              err
);

  logic [CRED_W-1:0] credits_q, credits_d;
  logic [CRED_W-1:0] after_issue;
  logic              err_q, err_d;

  assign need      = popcount(ipv_vec);
  assign full      = (credits_q == CREDITS_C);
  assign can_issue = (credits_q >= need);
  assign err       = err_q;

  // A return that would push the count past CREDITS has no row behind it.
  always_comb begin
    after_issue = issue ? (credits_q - need) : credits_q;
    credits_d   = after_issue;
    err_d       = err_q;
    if (cred_ret) begin
      if (after_issue == CREDITS_C) err_d = 1'b1;
      else                          credits_d = after_issue + CRED_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credits_q <= CREDITS_C;
      err_q     <= 1'b0;
    end else begin
      credits_q <= credits_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: rtl/smvm_batch_scheduler.sv
// Packs nonzero beats into K-lane batches and issues them against row credits; Kth/last beat -> iss_valid next cycle.
// in_ready low while a batch waits (ISSUE) or the matrix drains (DRAIN). Optional counters: SMVM_SCHED_STATS_EN.
module smvm_batch_scheduler
  import smvm_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  smvm_batch_scheduler_if.slave bus,
  input  logic                 cred_ret,
  output logic                 done,
  output logic                 err,
  output logic [15:0]          stat_batches,
  output logic [15:0]          stat_stall
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  fill_cnt_q, fill_cnt_d;
  logic              batch_last_q, batch_last_d;
  lane_t             lanes_q [K];
  lane_t             lanes_d [K];

  logic [K-1:0]      ipv_vec;
  logic [CRED_W-1:0] need;
  logic              can_issue, full, cred_err;
  logic              accept, iss_vld_int, iss_fire;

  always_comb begin
    for (int i = 0; i < K; i++) ipv_vec[K-1-i] = lanes_q[i].ipv;
  end

  // A batch with no row end consumes nothing and goes out immediately.
  assign iss_vld_int = (state_q == ST_ISSUE) && (can_issue || (need == '0));
  assign iss_fire    = iss_vld_int && bus.iss_ready && !rst;
  assign accept      = bus.in_valid && bus.in_ready;

  smvm_credit_ctr u_credit (
    .clk       (clk),
    .rst       (rst),
    .ipv_vec   (ipv_vec),
    .issue     (iss_fire),
    .cred_ret  (cred_ret),
    .need      (need),
    .can_issue (can_issue),
    .full      (full),
    .err       (cred_err)
  );

  always_comb begin
    state_d      = state_q;
    fill_cnt_d   = fill_cnt_q;
    batch_last_d = batch_last_q;
    lanes_d      = lanes_q;
    done         = 1'b0;
    case (state_q)
      ST_IDLE, ST_FILL: begin
        if (accept) begin
          lanes_d[fill_cnt_q[LANE_W-1:0]].val = bus.in_val;
          lanes_d[fill_cnt_q[LANE_W-1:0]].col = bus.in_col;
          lanes_d[fill_cnt_q[LANE_W-1:0]].ipv = bus.in_ipv;
          fill_cnt_d   = fill_cnt_q + CNT_W'(1);
          batch_last_d = bus.in_last;
          state_d      = ((fill_cnt_q == K_LAST) || bus.in_last) ? ST_ISSUE : ST_FILL;
        end
      end
      ST_ISSUE: begin
        if (iss_fire) begin
          for (int i = 0; i < K; i++) lanes_d[i] = '0;
          fill_cnt_d   = '0;
          batch_last_d = 1'b0;
          state_d      = batch_last_q ? ST_DRAIN : ST_FILL;
        end
      end
      ST_DRAIN: begin
        if (full) begin
          done    = !rst;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      fill_cnt_q   <= '0;
      batch_last_q <= 1'b0;
      for (int i = 0; i < K; i++) lanes_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      fill_cnt_q   <= fill_cnt_d;
      batch_last_q <= batch_last_d;
      lanes_q      <= lanes_d;
    end
  end

  // Lane 0 occupies the MSBs of every issue field.
  always_comb begin
    bus.iss_val = '0;
    bus.iss_col = '0;
    if (!rst) begin
      for (int i = 0; i < K; i++) begin
        bus.iss_val[(K-1-i)*VAL_W +: VAL_W] = lanes_q[i].val;
        bus.iss_col[(K-1-i)*COL_W +: COL_W] = lanes_q[i].col;
      end
    end
  end

  assign bus.iss_ipv   = rst ? '0 : ipv_vec;
  assign bus.iss_lanes = rst ? '0 : LANES_W'(fill_cnt_q);
  assign bus.iss_valid = iss_vld_int && !rst;
  assign bus.in_ready  = !rst && ((state_q == ST_IDLE) || (state_q == ST_FILL));
  assign err           = cred_err && !rst;

`ifdef SMVM_SCHED_STATS_EN
  logic [15:0] stat_batches_q, stat_batches_d;
  logic [15:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_batches_d = stat_batches_q;
    stat_stall_d   = stat_stall_q;
    if (iss_fire && (stat_batches_q != 16'hffff))
      stat_batches_d = stat_batches_q + 16'd1;
    if ((state_q == ST_ISSUE) && !iss_vld_int && (stat_stall_q != 16'hffff))
      stat_stall_d = stat_stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_batches_q <= '0;
      stat_stall_q   <= '0;
    end else begin
      stat_batches_q <= stat_batches_d;
      stat_stall_q   <= stat_stall_d;
    end
  end

  assign stat_batches = rst ? 16'd0 : stat_batches_q;
  assign stat_stall   = rst ? 16'd0 : stat_stall_q;
`else
  assign stat_batches = 16'd0;
  assign stat_stall   = 16'd0;
`endif

endmodule

// File: tb/tb_smvm_batch_scheduler.sv
// Directed + randomized bench for smvm_batch_scheduler against a queue-based
// batch/credit reference model.
module tb_smvm_batch_scheduler;
  import smvm_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cred_ret = 1'b0;
  logic        done, err;
  logic [15:0] stat_batches, stat_stall;

  smvm_batch_scheduler_if bus();

  smvm_batch_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .cred_ret     (cred_ret),
    .done         (done),
    .err          (err),
    .stat_batches (stat_batches),
    .stat_stall   (stat_stall)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: the open batch as queues plus a plain credit integer.
  logic [VAL_W-1:0] m_val[$];
  logic [COL_W-1:0] m_col[$];
  bit               m_ipv[$];
  bit               m_closed, m_last, m_drain, m_err;
  int               m_credits, m_batches, m_stalls;

  bit auto_ret, rand_rdy;
  bit last_acc;
  bit o_vld, o_in_rdy, o_done, o_err;
  logic [31:0] o_val;
  logic [3:0]  o_ipv;
  logic [2:0]  o_lanes;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_val.delete();
    m_col.delete();
    m_ipv.delete();
    m_closed  = 1'b0;
    m_last    = 1'b0;
    m_drain   = 1'b0;
    m_err     = 1'b0;
    m_credits = CREDITS;
    m_batches = 0;
    m_stalls  = 0;
  endfunction

  task automatic cycle();
    int need;
    logic [VAL_W*K-1:0] e_val;
    logic [COL_W*K-1:0] e_col;
    logic [K-1:0]       e_ipv;
    bit e_rdy, e_vld, e_done, acc, fire;
    if (auto_ret) cred_ret = (m_credits < CREDITS) && ($urandom_range(0, 1) == 1);
    if (rand_rdy) bus.iss_ready = ($urandom_range(0, 3) != 0);
    @(negedge clk);
    need  = 0;
    e_val = '0;
    e_col = '0;
    e_ipv = '0;
    foreach (m_val[i]) begin
      e_val[(K-1-i)*VAL_W +: VAL_W] = m_val[i];
      e_col[(K-1-i)*COL_W +: COL_W] = m_col[i];
      e_ipv[K-1-i] = m_ipv[i];
      need += int'(m_ipv[i]);
    end
    e_rdy  = !m_closed && !m_drain;
    e_vld  = m_closed && (m_credits >= need);
    e_done = m_drain && (m_credits == CREDITS);
    o_vld = bus.iss_valid; o_in_rdy = bus.in_ready; o_done = done; o_err = err;
    o_val = bus.iss_val; o_ipv = bus.iss_ipv; o_lanes = bus.iss_lanes;
    chk("in_ready", 32'(bus.in_ready), 32'(e_rdy));
    chk("iss_valid", 32'(bus.iss_valid), 32'(e_vld));
    chk("done", 32'(done), 32'(e_done));
    chk("err", 32'(err), 32'(m_err));
    if (e_vld) begin
      chk("iss_val", bus.iss_val, e_val);
      chk("iss_col", 32'(bus.iss_col), 32'(e_col));
      chk("iss_ipv", 32'(bus.iss_ipv), 32'(e_ipv));
      chk("iss_lanes", 32'(bus.iss_lanes), 32'(m_val.size()));
    end
    acc  = bus.in_valid && e_rdy;
    fire = e_vld && bus.iss_ready;
    if (m_closed && !e_vld) m_stalls++;
    if (fire) begin
      m_credits -= need;
      m_batches++;
      m_val.delete(); m_col.delete(); m_ipv.delete();
      m_closed = 1'b0;
      if (m_last) m_drain = 1'b1;
      m_last = 1'b0;
    end
    if (e_done) m_drain = 1'b0;
    if (cred_ret) begin
      if (m_credits == CREDITS) m_err = 1'b1;
      else m_credits++;
    end
    if (acc) begin
      m_val.push_back(bus.in_val);
      m_col.push_back(bus.in_col);
      m_ipv.push_back(bus.in_ipv);
      if (m_val.size() == K || bus.in_last) begin
        m_closed = 1'b1;
        m_last   = bus.in_last;
      end
    end
    last_acc = acc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic send_beat(input logic [VAL_W-1:0] v, input logic [COL_W-1:0] c,
                           input bit ipv, input bit last);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_val = v; bus.in_col = c; bus.in_ipv = ipv; bus.in_last = last;
    do begin
      cycle();
      n++;
    end while (!last_acc && n < 64);
    chk("beat_accept", 32'(last_acc), 32'd1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_rand(input bit ipv, input bit last);
    send_beat(VAL_W'($urandom), COL_W'($urandom), ipv, last);
  endtask

  task automatic drain(input string tag);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    auto_ret = 1'b1; rand_rdy = 1'b0;
    bus.iss_ready = 1'b1; bus.in_valid = 1'b0;
    while (!seen && n < 300) begin
      cycle();
      seen = o_done;
      n++;
    end
    chk({tag, "_done"}, 32'(seen), 32'd1);
    auto_ret = 1'b0;
    cred_ret = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.in_valid = 1'b0; cred_ret = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_iss_valid", 32'(bus.iss_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_lanes", 32'(bus.iss_lanes), 32'd0);
    chk("rst_iss_val", bus.iss_val, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_val = '0; bus.in_col = '0;
    bus.in_ipv = 1'b0; bus.in_last = 1'b0; bus.iss_ready = 1'b0;
    auto_ret = 1'b0; rand_rdy = 1'b0;
    model_reset();
    do_reset();

    // 4 beats ipv 0,1,0,1: issue the cycle after the last accept, two returns -> done
    bus.iss_ready = 1'b1;
    send_rand(1'b0, 1'b0); send_rand(1'b1, 1'b0);
    send_rand(1'b0, 1'b0); send_rand(1'b1, 1'b1);
    cycle();
    chk("t1_iss_valid", 32'(o_vld), 32'd1);
    chk("t1_lanes", 32'(o_lanes), 32'd4);
    chk("t1_ipv", 32'(o_ipv), 32'b0101);
    cred_ret = 1'b1; cycle(); cycle();
    cred_ret = 1'b0; cycle();
    chk("t1_done", 32'(o_done), 32'd1);

    // 6 beats: second batch has two lanes, lanes 2..3 zero
    for (int b = 0; b < 5; b++) send_rand(1'($urandom_range(0, 1)), 1'b0);
    send_rand(1'($urandom_range(0, 1)), 1'b1);
    cycle();
    chk("t2_lanes", 32'(o_lanes), 32'd2);
    chk("t2_zero_lanes", 32'(o_val[15:0]), 32'd0);
    drain("t2");

    // five full-row batches without returns: third batch stalls until credits reach 4
    bus.iss_ready = 1'b1;
    for (int b = 0; b < 12; b++) send_rand(1'b1, 1'b0);
    idle(3);
    chk("t3_stall", 32'(o_vld), 32'd0);
    cred_ret = 1'b1; cycle();
    cred_ret = 1'b0; idle(2);
    chk("t3_one_ret", 32'(o_vld), 32'd0);
    cred_ret = 1'b1; idle(3);
    chk("t3_three_ret", 32'(o_vld), 32'd0);
    cred_ret = 1'b0; cycle();
    chk("t3_release", 32'(o_vld), 32'd1);
    auto_ret = 1'b1;
    for (int b = 0; b < 7; b++) send_rand(1'b1, 1'b0);
    send_rand(1'b1, 1'b1);
    drain("t3");

    // ALU backpressure for 5 cycles: batch held, no beats accepted
    bus.iss_ready = 1'b0;
    for (int b = 0; b < 4; b++) send_rand(1'($urandom_range(0, 1)), 1'b0);
    for (int h = 0; h < 5; h++) begin
      cycle();
      chk("t4_hold_vld", 32'(o_vld), 32'd1);
      chk("t4_hold_rdy", 32'(o_in_rdy), 32'd0);
    end
    bus.iss_ready = 1'b1;
    cycle();
    chk("t4_issue", 32'(o_vld), 32'd1);
    send_rand(1'b1, 1'b1);
    drain("t4");

    // issue with need 1 and a return in the same cycle at credits 1
    bus.iss_ready = 1'b1;
    for (int b = 0; b < 4; b++) send_rand(1'b1, 1'b0);
    send_rand(1'b1, 1'b0); send_rand(1'b1, 1'b0); send_rand(1'b1, 1'b0); send_rand(1'b0, 1'b0);
    send_rand(1'b1, 1'b1);
    cred_ret = 1'b1; cycle();
    chk("t5_issue_ret", 32'(o_vld), 32'd1);
    idle(7);
    cred_ret = 1'b0; cycle();
    chk("t5_done", 32'(o_done), 32'd1);
    cred_ret = 1'b1; cycle();
    cred_ret = 1'b0; cycle();
    chk("t5_err", 32'(o_err), 32'd1);
    send_rand(1'b1, 1'b1);
    drain("t5");

    // reset with a partial batch, then a one-beat matrix
    bus.iss_ready = 1'b1;
    send_rand(1'b1, 1'b0); send_rand(1'b0, 1'b0);
    do_reset();
    cycle();
    chk("t6_in_ready", 32'(o_in_rdy), 32'd1);
    chk("t6_iss_valid", 32'(o_vld), 32'd0);
    chk("t6_err", 32'(o_err), 32'd0);
    send_rand(1'b1, 1'b1);
    cycle();
    chk("t6_lanes", 32'(o_lanes), 32'd1);
    drain("t6");

    // random matrices with random ALU readiness and row returns
    for (int m = 0; m < 6; m++) begin
      int len;
      len = $urandom_range(1, 11);
      rand_rdy = 1'b1;
      auto_ret = 1'b1;
      for (int b = 0; b < len; b++) send_rand(1'($urandom_range(0, 1)), b == len - 1);
      drain("rand");
    end

`ifdef SMVM_SCHED_STATS_EN
    chk("stat_batches", 32'(stat_batches), 32'(m_batches));
    chk("stat_stall", 32'(stat_stall), 32'(m_stalls));
`else
    chk("stat_batches_off", 32'(stat_batches), 32'd0);
    chk("stat_stall_off", 32'(stat_stall), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
